// File: rtl/dram_read_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) between the read arbiter and the MIG
// AXI slave port.
//   master modport : arbiter side, drives AR fields and m_rready
//   slave  modport : memory side, drives m_arready and R fields
interface dram_read_arbiter_if #(
    parameter int ID_W = 8
);
    logic [ID_W-1:0] m_arid;
    logic [32:0]     m_araddr;
    logic [7:0]      m_arlen;
    logic [2:0]      m_arsize;
    logic [1:0]      m_arburst;
    logic            m_arvalid;
    logic            m_arready;

    logic [ID_W-1:0] m_rid;
    logic [255:0]    m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic            m_rvalid;
    logic            m_rready;

    modport master (
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready
    );

    modport slave (
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready
    );
endinterface

// File: rtl/dram_read_arbiter.sv
// dram_read_arbiter
//   Round-robin arbiter that merges per-engine DRAM read burst requests onto
//   one AXI4 AR channel and routes R beats back to the engine encoded in the
//   upper 4 bits of the AXI ID (lower bits carry the engine's own rd_id).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rd_id_in/rd_addr_in/rd_len_in/rd_info_valid_in -> rd_info_rdy_out
//                       per-engine request bus (flattened, engine e at slice e)
//   rd_data_out         R data, broadcast to all engines
//   rd_data_valid_out   one-hot beat valid, rd_data_rdy_in per-engine ready
//   rd_err_out          sticky error (unmapped ID, bad RRESP, counter underflow)
//   axi                 AXI4 AR/R channels (master modport)
//
// Build option:
//   DRAM_RD_OUTSTANDING_LIMIT_EN  when defined, per-engine in-flight burst
//   counters gate eligibility at MAX_OUTSTANDING and flag completion
//   underflow. When undefined, eligibility is rd_info_valid_in alone.
module dram_read_arbiter #(
    parameter int NUM_ENGINES         = 4,
    parameter int C0_C_S_AXI_ID_WIDTH = 8,
    parameter int MAX_OUTSTANDING     = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_ENGINES*(C0_C_S_AXI_ID_WIDTH-4)-1:0] rd_id_in,
    input  logic [NUM_ENGINES*33-1:0]                   rd_addr_in,
    input  logic [NUM_ENGINES*8-1:0]                    rd_len_in,
    input  logic [NUM_ENGINES-1:0]                      rd_info_valid_in,
    output logic [NUM_ENGINES-1:0]                      rd_info_rdy_out,
    output logic [255:0]                                rd_data_out,
    output logic [NUM_ENGINES-1:0]                      rd_data_valid_out,
    input  logic [NUM_ENGINES-1:0]                      rd_data_rdy_in,
    output logic                                        rd_err_out,
    dram_read_arbiter_if.master                         axi
);
    localparam int RID_W = C0_C_S_AXI_ID_WIDTH - 4;
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    logic [RID_W-1:0]       req_id   [NUM_ENGINES];
    logic [32:0]            req_addr [NUM_ENGINES];
    logic [7:0]             req_len  [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] eligible;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic             found;
    logic             ar_free;
    logic             grant;

    logic [3:0] r_eng;
    logic       r_mapped;
    logic       r_fire;
    logic       r_err;
    logic       cnt_err;

    for (genvar e = 0; e < NUM_ENGINES; e++) begin : g_unpack
        assign req_id[e]   = rd_id_in[e*RID_W +: RID_W];
        assign req_addr[e] = rd_addr_in[e*33 +: 33];
        assign req_len[e]  = rd_len_in[e*8 +: 8];
    end

    // ---------------- AR arbitration ----------------
    assign ar_free = !axi.m_arvalid || axi.m_arready;

    // Scan from rr_ptr upward, wrapping, and keep the first eligible engine.
    always_comb begin
        logic [PTR_W:0] sum;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_ENGINES))
                sum = sum - (PTR_W+1)'(NUM_ENGINES);
            if (!found && eligible[sum[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = sum[PTR_W-1:0];
            end
        end
    end

    assign grant = ar_free && found;

    always_comb begin
        rd_info_rdy_out = '0;
        if (grant)
            rd_info_rdy_out[winner] = 1'b1;
    end

    assign axi.m_arsize  = 3'b101;
    assign axi.m_arburst = 2'b01;

    // ---------------- R routing ----------------
    assign r_eng       = axi.m_rid[C0_C_S_AXI_ID_WIDTH-1 -: 4];
    assign r_mapped    = ({1'b0, r_eng} < 5'(NUM_ENGINES));
    assign rd_data_out = axi.m_rdata;

    // Unmapped IDs are sunk so a stray beat cannot wedge the R channel.
    always_comb begin
        rd_data_valid_out = '0;
        axi.m_rready      = axi.m_rvalid;
        if (r_mapped) begin
            rd_data_valid_out[r_eng[PTR_W-1:0]] = axi.m_rvalid;
            axi.m_rready = axi.m_rvalid && rd_data_rdy_in[r_eng[PTR_W-1:0]];
        end
    end

    assign r_fire = axi.m_rvalid && axi.m_rready;
    assign r_err  = r_fire && (!r_mapped || (axi.m_rresp != 2'b00));

    // ---------------- per-engine outstanding counters ----------------
`ifdef DRAM_RD_OUTSTANDING_LIMIT_EN
    logic [NUM_ENGINES-1:0] underflow;

    for (genvar e = 0; e < NUM_ENGINES; e++) begin : g_cnt
        logic [3:0] cnt;
        logic       inc;
        logic       dec;

        assign inc          = grant && (winner == PTR_W'(e));
        assign dec          = r_fire && r_mapped && axi.m_rlast && (r_eng == 4'(e));
        assign eligible[e]  = rd_info_valid_in[e] && (cnt < 4'(MAX_OUTSTANDING));
        // A completion with nothing in flight (e.g. a burst issued before a
        // reset) is reported; the count saturates at zero.
        assign underflow[e] = dec && (cnt == 4'd0);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                cnt <= 4'd0;
            else if (inc && !dec)
                cnt <= cnt + 4'd1;
            else if (dec && !inc && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
        end
    end

    assign cnt_err = |underflow;
`else
    assign eligible = rd_info_valid_in;
    assign cnt_err  = 1'b0;
`endif

    // ---------------- AR holding register, pointer, error flag ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            axi.m_arvalid <= 1'b0;
            axi.m_arid    <= '0;
            axi.m_araddr  <= '0;
            axi.m_arlen   <= '0;
            rr_ptr        <= '0;
            rd_err_out    <= 1'b0;
        end else begin
            if (grant) begin
                axi.m_arvalid <= 1'b1;
                axi.m_arid    <= {4'(winner), req_id[winner]};
                axi.m_araddr  <= req_addr[winner];
                axi.m_arlen   <= req_len[winner];
                rr_ptr        <= (winner == PTR_W'(NUM_ENGINES-1)) ? '0 : winner + 1'b1;
            end else if (axi.m_arready) begin
                axi.m_arvalid <= 1'b0;
            end
            if (r_err || cnt_err)
                rd_err_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_read_arbiter.sv
// Directed bench for dram_read_arbiter (4 engines, 8-bit AXI ID,
// MAX_OUTSTANDING=2). Inputs change 1 ns after posedge, outputs are
// sampled on the negedge.
module tb_dram_read_arbiter;
    localparam int NE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [15:0]   rd_id_in;
    logic [131:0]  rd_addr_in;
    logic [31:0]   rd_len_in;
    logic [3:0]    rd_info_valid_in;
    logic [3:0]    rd_info_rdy_out;
    logic [255:0]  rd_data_out;
    logic [3:0]    rd_data_valid_out;
    logic [3:0]    rd_data_rdy_in;
    logic          rd_err_out;

    dram_read_arbiter_if #(.ID_W(8)) axi ();

    dram_read_arbiter #(
        .NUM_ENGINES(NE), .C0_C_S_AXI_ID_WIDTH(8), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_id_in(rd_id_in), .rd_addr_in(rd_addr_in), .rd_len_in(rd_len_in),
        .rd_info_valid_in(rd_info_valid_in), .rd_info_rdy_out(rd_info_rdy_out),
        .rd_data_out(rd_data_out), .rd_data_valid_out(rd_data_valid_out),
        .rd_data_rdy_in(rd_data_rdy_in), .rd_err_out(rd_err_out),
        .axi(axi)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clr_r();
        axi.m_rvalid = 1'b0;
        axi.m_rid    = '0;
        axi.m_rdata  = '0;
        axi.m_rresp  = 2'b00;
        axi.m_rlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rd_info_valid_in = '0;
        rd_data_rdy_in   = '0;
        axi.m_arready    = 1'b0;
        clr_r();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [7:0]   rid;
        logic         rvalid;
        logic [3:0]   rdy;
        logic [3:0]   exp_vld;
        logic         exp_rready;
    } rvec_t;

    rvec_t rv [7];

    initial begin
        int          grants;
        int          beat;
        logic [7:0]  exp_id;
        logic [5:0]  pat;
        logic [255:0] d;

        // Mapped IDs, RRESP OKAY, no RLAST: pure combinational routing.
        rv[0] = '{8'h05, 1'b1, 4'b0001, 4'b0001, 1'b1};
        rv[1] = '{8'h15, 1'b1, 4'b0000, 4'b0010, 1'b0};
        rv[2] = '{8'h2A, 1'b1, 4'b0100, 4'b0100, 1'b1};
        rv[3] = '{8'h3F, 1'b1, 4'b0111, 4'b1000, 1'b0};
        rv[4] = '{8'h30, 1'b1, 4'b1000, 4'b1000, 1'b1};
        rv[5] = '{8'h10, 1'b0, 4'b1111, 4'b0000, 1'b0};
        rv[6] = '{8'h20, 1'b1, 4'b1011, 4'b0100, 1'b0};

        for (int e = 0; e < NE; e++) begin
            rd_id_in[e*4 +: 4]     = 4'(e + 5);
            rd_addr_in[e*33 +: 33] = (e == 2) ? 33'h1000 : 33'h1_0000_0000 + 33'(e);
            rd_len_in[e*8 +: 8]    = (e == 2) ? 8'd7 : 8'(e);
        end

        // ---- reset state ----
        rst = 1'b0;
        rd_info_valid_in = '0;
        rd_data_rdy_in   = '0;
        axi.m_arready    = 1'b0;
        clr_r();
        settle();
        chk("rst_arvalid", 256'(axi.m_arvalid), 256'(0));
        chk("rst_arid",    256'(axi.m_arid),    256'(0));
        chk("rst_araddr",  256'(axi.m_araddr),  256'(0));
        chk("rst_arlen",   256'(axi.m_arlen),   256'(0));
        chk("rst_rdy",     256'(rd_info_rdy_out), 256'(0));
        chk("rst_dvld",    256'(rd_data_valid_out), 256'(0));
        chk("rst_rready",  256'(axi.m_rready),  256'(0));
        chk("rst_err",     256'(rd_err_out),    256'(0));
        chk("arsize",      256'(axi.m_arsize),  256'(3'b101));
        chk("arburst",     256'(axi.m_arburst), 256'(2'b01));
        do_reset();

        // ---- R routing table ----
        for (int i = 0; i < 7; i++) begin
            d = {8{32'hC0DE_0000 + 32'(i)}};
            axi.m_rid      = rv[i].rid;
            axi.m_rvalid   = rv[i].rvalid;
            axi.m_rdata    = d;
            rd_data_rdy_in = rv[i].rdy;
            settle();
            chk($sformatf("tbl%0d_vld", i),    256'(rd_data_valid_out), 256'(rv[i].exp_vld));
            chk($sformatf("tbl%0d_rready", i), 256'(axi.m_rready),      256'(rv[i].exp_rready));
            chk($sformatf("tbl%0d_data", i),   rd_data_out,             d);
            tick();
        end
        clr_r();
        settle();
        chk("tbl_err", 256'(rd_err_out), 256'(0));

        // ---- round-robin: all valid, arready high ----
        do_reset();
        axi.m_arready    = 1'b1;
        rd_info_valid_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("rr%0d_rdy", k), 256'(rd_info_rdy_out), 256'(4'b0001 << (k % 4)));
            if (k > 0) begin
                exp_id = {4'((k - 1) % 4), 4'(((k - 1) % 4) + 5)};
                chk($sformatf("rr%0d_arid", k), 256'(axi.m_arid), 256'(exp_id));
                chk($sformatf("rr%0d_arvalid", k), 256'(axi.m_arvalid), 256'(1));
            end
            tick();
        end
        rd_info_valid_in = '0;

        // ---- AR backpressure ----
        do_reset();
        rd_info_valid_in = 4'b0100;
        settle();
        chk("bp_grant2", 256'(rd_info_rdy_out), 256'(4'b0100));
        tick();
        rd_info_valid_in = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("bp%0d_arvalid", c), 256'(axi.m_arvalid), 256'(1));
            chk($sformatf("bp%0d_araddr", c),  256'(axi.m_araddr),  256'(33'h1000));
            chk($sformatf("bp%0d_arlen", c),   256'(axi.m_arlen),   256'(7));
            chk($sformatf("bp%0d_arid", c),    256'(axi.m_arid),    256'(8'h27));
            chk($sformatf("bp%0d_nogrant", c), 256'(rd_info_rdy_out), 256'(0));
            tick();
        end
        axi.m_arready = 1'b1;
        settle();
        chk("bp_grant0", 256'(rd_info_rdy_out), 256'(4'b0001));
        tick();
        rd_info_valid_in = '0;
        settle();
        chk("bp_arid0", 256'(axi.m_arid), 256'(8'h05));
        tick();
        settle();
        chk("bp_idle", 256'(axi.m_arvalid), 256'(0));

        // ---- outstanding limit on engine 1 ----
        do_reset();
        axi.m_arready    = 1'b1;
        rd_info_valid_in = 4'b0010;
        grants = 0;
        for (int c = 0; c < 6; c++) begin
            settle();
            if (rd_info_rdy_out == 4'b0010) grants++;
            tick();
        end
`ifdef DRAM_RD_OUTSTANDING_LIMIT_EN
        chk("lim_grants", 256'(grants), 256'(2));
        axi.m_rid      = 8'h13;
        axi.m_rvalid   = 1'b1;
        axi.m_rlast    = 1'b1;
        rd_data_rdy_in = 4'b0010;
        settle();
        chk("lim_rready", 256'(axi.m_rready), 256'(1));
        chk("lim_still_blocked", 256'(rd_info_rdy_out), 256'(0));
        tick();
        clr_r();
        settle();
        chk("lim_third_grant", 256'(rd_info_rdy_out), 256'(4'b0010));
        tick();
        settle();
        chk("lim_full_again", 256'(rd_info_rdy_out), 256'(0));
`else
        chk("lim_grants", 256'(grants), 256'(6));
`endif
        rd_info_valid_in = '0;
        chk("lim_err", 256'(rd_err_out), 256'(0));

        // ---- R burst to engine 3 with backpressure ----
        do_reset();
        axi.m_arready    = 1'b1;
        rd_info_valid_in = 4'b1000;
        settle();
        chk("rb_req_grant", 256'(rd_info_rdy_out), 256'(4'b1000));
        tick();
        rd_info_valid_in = '0;
        pat  = 6'b111001;   // bit c = engine 3 ready in cycle c
        beat = 0;
        for (int c = 0; c < 6; c++) begin
            d = {8{32'hA000_0000 + 32'(beat)}};
            axi.m_rid      = 8'h35;
            axi.m_rvalid   = 1'b1;
            axi.m_rdata    = d;
            axi.m_rlast    = (beat == 3);
            rd_data_rdy_in = {pat[c], 3'b000};
            settle();
            chk($sformatf("rb%0d_vld", c),    256'(rd_data_valid_out), 256'(4'b1000));
            chk($sformatf("rb%0d_rready", c), 256'(axi.m_rready), 256'(pat[c]));
            chk($sformatf("rb%0d_data", c),   rd_data_out, {8{32'hA000_0000 + 32'(beat)}});
            if (pat[c]) beat++;
            tick();
        end
        clr_r();
        rd_data_rdy_in = '0;
        settle();
        chk("rb_err", 256'(rd_err_out), 256'(0));

        // ---- bad RRESP: delivered, error set ----
        d = {8{32'h5EED_BEEF}};
        axi.m_rid      = 8'h20;
        axi.m_rvalid   = 1'b1;
        axi.m_rresp    = 2'b10;
        axi.m_rdata    = d;
        rd_data_rdy_in = 4'b0100;
        settle();
        chk("resp_vld",    256'(rd_data_valid_out), 256'(4'b0100));
        chk("resp_data",   rd_data_out, d);
        chk("resp_rready", 256'(axi.m_rready), 256'(1));
        tick();
        clr_r();
        settle();
        chk("resp_err", 256'(rd_err_out), 256'(1));

        // ---- unmapped ID sunk, sticky error ----
        do_reset();
        settle();
        chk("unm_err_clr", 256'(rd_err_out), 256'(0));
        axi.m_rid    = 8'hF0;
        axi.m_rvalid = 1'b1;
        settle();
        chk("unm_rready", 256'(axi.m_rready), 256'(1));
        chk("unm_vld",    256'(rd_data_valid_out), 256'(0));
        tick();
        clr_r();
        settle();
        chk("unm_err", 256'(rd_err_out), 256'(1));
        tick(); tick(); tick();
        settle();
        chk("unm_err_sticky", 256'(rd_err_out), 256'(1));

        // ---- completion with nothing outstanding ----
        do_reset();
        axi.m_rid      = 8'h00;
        axi.m_rvalid   = 1'b1;
        axi.m_rlast    = 1'b1;
        rd_data_rdy_in = 4'b0001;
        settle();
        chk("uf_vld", 256'(rd_data_valid_out), 256'(4'b0001));
        tick();
        clr_r();
        settle();
`ifdef DRAM_RD_OUTSTANDING_LIMIT_EN
        chk("uf_err", 256'(rd_err_out), 256'(1));
`else
        chk("uf_err", 256'(rd_err_out), 256'(0));
`endif

        // ---- asynchronous reset mid-cycle with AR pending ----
        do_reset();
        rd_info_valid_in = 4'b0001;
        tick();
        rd_info_valid_in = 4'b0010;
        tick();
        rd_info_valid_in = '0;
        settle();
        chk("ar_pending", 256'(axi.m_arvalid), 256'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_arvalid", 256'(axi.m_arvalid), 256'(0));
        chk("arst_arid",    256'(axi.m_arid),    256'(0));
        tick();
        rst = 1'b1;
        rd_info_valid_in = 4'b0011;
        settle();
        chk("arst_ptr0", 256'(rd_info_rdy_out), 256'(4'b0001));
        tick();
        rd_info_valid_in = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
